tdm_demux: RTL and testbench

Serial time-division demultiplexer: the receiving end of a 2:1 bit-interleaved link whose transmitter muxes channel A and channel B onto one wire under an alternating select. It recovers the select phase from a frame-sync strobe, steers each incoming bit to its channel, deserializes each channel into a W-bit word and presents both words with a one-cycle valid pulse. It sits directly behind the serial link pin and feeds the two-channel datapath.

---
 rtl/tdm_pkg.sv | 20 ++
 rtl/demux_shift.sv | 32 +++
 rtl/tdm_demux.sv | 121 ++++++++++++
 tb/tb_tdm_demux.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the 2:1 bit-interleaved TDM demultiplexer.
package tdm_pkg;

    localparam logic IDLE = 1'b0;
    localparam logic RECV = 1'b1;

    localparam int W_DEF = 4;

    function automatic int cnt_width(input int w);
        return $clog2(2 * w);
    endfunction

    localparam int CNT_W = cnt_width(W_DEF);

    typedef enum logic {
        ST_IDLE = IDLE,
        ST_RECV = RECV
    } state_e;

endpackage

// File: rtl/demux_shift.sv
// W-bit MSB-first shift register with enable and async active-low clear.
module demux_shift #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sh_q;
    logic [W-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (en_i) begin
            sh_d = {sh_q[W-2:0], d_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q_o = sh_q;

endmodule

// File: rtl/tdm_demux.sv
// Receiver for a 2:1 bit-interleaved serial link: frame sync, channel
// steering, per-channel deserialization and registered word outputs.
import tdm_pkg::*;

module tdm_demux #(
    parameter int W = W_DEF
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         en,
    input  logic         sync,
    input  logic         din,
    output logic [W-1:0] qa,
    output logic [W-1:0] qb,
    output logic         valid,
    output logic         err,
    output logic         busy,
    output logic         chan
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(2 * W - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  qa_q, qa_d;
    logic [W-1:0]  qb_q, qb_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    logic          sel;
    logic          sh_a_en;
    logic          sh_b_en;
    logic [W-1:0]  sh_a;
    logic [W-1:0]  sh_b;

    assign sel = cnt_q[0];
    // A sync bit is always A[W-1], even when an abort lands on a B slot.
    assign sh_a_en = en & (~sel | sync);
    assign sh_b_en = en & sel & ~sync;

    demux_shift #(.W(W)) u_sh_a (
        .clk_i  (Clock),
        .rst_ni (Resetn),
        .en_i   (sh_a_en),
        .d_i    (din),
        .q_o    (sh_a)
    );

    demux_shift #(.W(W)) u_sh_b (
        .clk_i  (Clock),
        .rst_ni (Resetn),
        .en_i   (sh_b_en),
        .d_i    (din),
        .q_o    (sh_b)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qa_d    = qa_q;
        qb_d    = qb_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en && sync) begin
                    state_d = ST_RECV;
                    cnt_d   = ONE;
                end
            end
            ST_RECV: begin
                if (en) begin
                    if (sync) begin
                        err_d = 1'b1;
                        cnt_d = ONE;
                    end else if (cnt_q == LAST) begin
                        qa_d    = sh_a;
                        qb_d    = {sh_b[W-2:0], din};
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            qa_q    <= '0;
            qb_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qa_q    <= qa_d;
            qb_q    <= qb_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign qa    = qa_q;
    assign qb    = qb_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = (state_q == ST_RECV);
    assign chan  = cnt_q[0];

endmodule

// File: tb/tb_tdm_demux.sv
// Directed vector bench for tdm_demux with W=4.
module tb_tdm_demux;

    logic       Clock;
    logic       Resetn;
    logic       en;
    logic       sync;
    logic       din;
    logic [3:0] qa;
    logic [3:0] qb;
    logic       valid;
    logic       err;
    logic       busy;
    logic       chan;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic       en;
        logic       sync;
        logic       din;
        logic       valid;
        logic       err;
        logic       busy;
        logic       chan;
        logic [3:0] qa;
        logic [3:0] qb;
    } vec_t;

    vec_t vecs[$];

    tdm_demux #(.W(4)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .en     (en),
        .sync   (sync),
        .din    (din),
        .qa     (qa),
        .qb     (qb),
        .valid  (valid),
        .err    (err),
        .busy   (busy),
        .chan   (chan)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic add(input logic e, input logic s, input logic d,
                       input logic v, input logic er, input logic b,
                       input logic c, input logic [3:0] a,
                       input logic [3:0] bb);
        vec_t t;
        t.en = e; t.sync = s; t.din = d;
        t.valid = v; t.err = er; t.busy = b; t.chan = c;
        t.qa = a; t.qb = bb;
        vecs.push_back(t);
    endtask

    task automatic bit_in(input logic e, input logic s, input logic d);
        @(negedge Clock);
        en = e;
        sync = s;
        din = d;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] got,
                         input logic [11:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got v/e/b/c/qa/qb=%b required %b",
                     name, got, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {valid, err, busy, chan, qa, qb};
    endfunction

    initial begin
        logic [7:0] fr;
        Resetn = 1'b0;
        en = 1'b0;
        sync = 1'b0;
        din = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_state", outs(), 12'h000);
        @(negedge Clock);
        Resetn = 1'b1;

        // basic frame: A=1011 B=0110
        add(1,1,1, 0,0,1,1, 4'h0,4'h0);
        add(1,0,0, 0,0,1,0, 4'h0,4'h0);
        add(1,0,0, 0,0,1,1, 4'h0,4'h0);
        add(1,0,1, 0,0,1,0, 4'h0,4'h0);
        add(1,0,1, 0,0,1,1, 4'h0,4'h0);
        add(1,0,1, 0,0,1,0, 4'h0,4'h0);
        add(1,0,1, 0,0,1,1, 4'h0,4'h0);
        add(1,0,0, 1,0,0,0, 4'hB,4'h6);
        add(0,0,0, 0,0,0,0, 4'hB,4'h6);
        // idle noise
        for (int i = 0; i < 10; i++)
            add(1,0,1'(i & 1), 0,0,0,0, 4'hB,4'h6);
        // back-to-back: 1011/0110 then 0011/1111
        add(1,1,1, 0,0,1,1, 4'hB,4'h6);
        add(1,0,0, 0,0,1,0, 4'hB,4'h6);
        add(1,0,0, 0,0,1,1, 4'hB,4'h6);
        add(1,0,1, 0,0,1,0, 4'hB,4'h6);
        add(1,0,1, 0,0,1,1, 4'hB,4'h6);
        add(1,0,1, 0,0,1,0, 4'hB,4'h6);
        add(1,0,1, 0,0,1,1, 4'hB,4'h6);
        add(1,0,0, 1,0,0,0, 4'hB,4'h6);
        add(1,1,0, 0,0,1,1, 4'hB,4'h6);
        add(1,0,1, 0,0,1,0, 4'hB,4'h6);
        add(1,0,0, 0,0,1,1, 4'hB,4'h6);
        add(1,0,1, 0,0,1,0, 4'hB,4'h6);
        add(1,0,1, 0,0,1,1, 4'hB,4'h6);
        add(1,0,1, 0,0,1,0, 4'hB,4'h6);
        add(1,0,1, 0,0,1,1, 4'hB,4'h6);
        add(1,0,1, 1,0,0,0, 4'h3,4'hF);
        // abort at bit 5, restart with A=0101 B=1100
        add(1,1,1, 0,0,1,1, 4'h3,4'hF);
        add(1,0,0, 0,0,1,0, 4'h3,4'hF);
        add(1,0,0, 0,0,1,1, 4'h3,4'hF);
        add(1,0,1, 0,0,1,0, 4'h3,4'hF);
        add(1,0,1, 0,0,1,1, 4'h3,4'hF);
        add(1,1,0, 0,1,1,1, 4'h3,4'hF);
        add(1,0,1, 0,0,1,0, 4'h3,4'hF);
        add(1,0,1, 0,0,1,1, 4'h3,4'hF);
        add(1,0,1, 0,0,1,0, 4'h3,4'hF);
        add(1,0,0, 0,0,1,1, 4'h3,4'hF);
        add(1,0,0, 0,0,1,0, 4'h3,4'hF);
        add(1,0,1, 0,0,1,1, 4'h3,4'hF);
        add(1,0,0, 1,0,0,0, 4'h5,4'hC);
        // stall 3 cycles after bit 5; sync is ignored while en=0
        add(1,1,1, 0,0,1,1, 4'h5,4'hC);
        add(1,0,0, 0,0,1,0, 4'h5,4'hC);
        add(1,0,0, 0,0,1,1, 4'h5,4'hC);
        add(1,0,1, 0,0,1,0, 4'h5,4'hC);
        add(1,0,1, 0,0,1,1, 4'h5,4'hC);
        add(1,0,1, 0,0,1,0, 4'h5,4'hC);
        add(0,1,1, 0,0,1,0, 4'h5,4'hC);
        add(0,0,0, 0,0,1,0, 4'h5,4'hC);
        add(0,1,0, 0,0,1,0, 4'h5,4'hC);
        add(1,0,1, 0,0,1,1, 4'h5,4'hC);
        add(1,0,0, 1,0,0,0, 4'hB,4'h6);
        // sync on the last bit aborts, then A=0101 B=1100
        add(1,1,1, 0,0,1,1, 4'hB,4'h6);
        add(1,0,0, 0,0,1,0, 4'hB,4'h6);
        add(1,0,0, 0,0,1,1, 4'hB,4'h6);
        add(1,0,1, 0,0,1,0, 4'hB,4'h6);
        add(1,0,1, 0,0,1,1, 4'hB,4'h6);
        add(1,0,1, 0,0,1,0, 4'hB,4'h6);
        add(1,0,1, 0,0,1,1, 4'hB,4'h6);
        add(1,1,0, 0,1,1,1, 4'hB,4'h6);
        add(1,0,1, 0,0,1,0, 4'hB,4'h6);
        add(1,0,1, 0,0,1,1, 4'hB,4'h6);
        add(1,0,1, 0,0,1,0, 4'hB,4'h6);
        add(1,0,0, 0,0,1,1, 4'hB,4'h6);
        add(1,0,0, 0,0,1,0, 4'hB,4'h6);
        add(1,0,1, 0,0,1,1, 4'hB,4'h6);
        add(1,0,0, 1,0,0,0, 4'h5,4'hC);
        add(0,0,0, 0,0,0,0, 4'h5,4'hC);

        for (int i = 0; i < vecs.size(); i++) begin
            bit_in(vecs[i].en, vecs[i].sync, vecs[i].din);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].valid, vecs[i].err, vecs[i].busy,
                   vecs[i].chan, vecs[i].qa, vecs[i].qb});
        end

        // async reset mid-frame at bit 3
        bit_in(1, 1, 1);
        bit_in(1, 0, 0);
        bit_in(1, 0, 0);
        check("pre_reset_busy", outs(), {4'b0011, 4'h5, 4'hC});
        #2;
        Resetn = 1'b0;
        #1;
        check("async_reset", outs(), 12'h000);
        @(negedge Clock);
        Resetn = 1'b1;
        en = 1'b0;
        sync = 1'b0;

        // post-reset frame A=0011 B=1111
        fr = 8'b0101_1111;
        for (int i = 7; i >= 0; i--) begin
            bit_in(1'b1, i == 7, fr[i]);
        end
        check("post_reset_frame", outs(), {4'b1000, 4'h3, 4'hF});
        bit_in(1'b0, 1'b0, 1'b0);
        check("post_reset_idle", outs(), {4'b0000, 4'h3, 4'hF});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
